// File: rtl/fetch_pkg.sv
// Shared types for the half-word fetch front end: queue entry layout and sizing.
// Entries carry FETCH_ADDR_W address bits, so a controller ADDR_W must not exceed it.
package fetch_pkg;
    localparam int FETCH_ADDR_W = 32;
    localparam int QUEUE_DEPTH  = 2;
    localparam int OCC_W        = 2;
    localparam int HW_BYTES     = 2;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] addr;
        logic [31:0]             data;
    } fetch_entry_t;

    // Upper half is the lower address; off selects which half is presented.
    function automatic logic [15:0] hw_select(input logic [31:0] word, input logic off);
        return off ? word[15:0] : word[31:16];
    endfunction
endpackage

// File: rtl/fetch_word_queue.sv
// Two-entry word FIFO; push visible at the head one cycle later, clear wins over push/pop.
// No internal backpressure: the controller never pushes when full or pops when empty.
module fetch_word_queue
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               push_i,
    input  fetch_entry_t       push_ent_i,
    input  logic               pop_i,
    output fetch_entry_t       head_o,
    output logic [OCC_W-1:0]   occ_o
);
    fetch_entry_t      ent0_q, ent0_d;
    fetch_entry_t      ent1_q, ent1_d;
    logic [OCC_W-1:0]  occ_q, occ_d;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        if (clear_i) begin
            occ_d = '0;
        end else if (push_i && pop_i) begin
            if (occ_q == OCC_W'(QUEUE_DEPTH)) begin
                ent0_d = ent1_q;
                ent1_d = push_ent_i;
            end else begin
                ent0_d = push_ent_i;
            end
        end else if (push_i) begin
            if (occ_q == '0) begin
                ent0_d = push_ent_i;
            end else begin
                ent1_d = push_ent_i;
            end
            occ_d = occ_q + OCC_W'(1);
        end else if (pop_i) begin
            ent0_d = ent1_q;
            occ_d  = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= '0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign head_o = ent0_q;
    assign occ_o  = occ_q;
endmodule

// File: rtl/halfword_fetch_ctrl.sv
// Fetches 32-bit cache words into a 2-deep queue and streams 16-bit half-words with their PCs.
// Ack to hw_valid: 1 cycle; hw_ready low holds the output while prefetch fills the queue.
module halfword_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              ic_req,
    output logic [ADDR_W-1:0] ic_addr,
    input  logic              ic_rdy,
    input  logic              ic_ack,
    input  logic [31:0]       ic_rdata,
    output logic              hw_valid,
    output logic [15:0]       hw_data,
    output logic [ADDR_W-1:0] hw_pc,
    input  logic              hw_ready
);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              pend_q, pend_d;
    logic              drop_q, drop_d;
    logic              off_q, off_d;
    logic              poff_q, poff_d;

    logic [OCC_W-1:0]  occ;
    fetch_entry_t      head;
    fetch_entry_t      push_ent;
    logic              issue, ack_live, push, pop, consume;

    assign ic_req   = !rst && !redirect_valid && !pend_q && (occ < OCC_W'(QUEUE_DEPTH));
    assign issue    = ic_req && ic_rdy;
    // Acks with nothing outstanding (e.g. right after reset) are ignored.
    assign ack_live = ic_ack && pend_q;
    assign push     = ack_live && !drop_q && !redirect_valid;
    assign hw_valid = (occ != '0);
    assign consume  = hw_valid && hw_ready && !redirect_valid;
    assign pop      = consume && off_q;
    assign push_ent = '{addr: FETCH_ADDR_W'(req_addr_q), data: ic_rdata};

    fetch_word_queue u_queue (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (redirect_valid),
        .push_i     (push),
        .push_ent_i (push_ent),
        .pop_i      (pop),
        .head_o     (head),
        .occ_o      (occ)
    );

    always_comb begin
        fetch_addr_d = fetch_addr_q;
        req_addr_d   = req_addr_q;
        pend_d       = pend_q;
        drop_d       = drop_q;
        off_d        = off_q;
        poff_d       = poff_q;
        if (redirect_valid) begin
            fetch_addr_d = redirect_pc & WORD_MASK;
            poff_d       = redirect_pc[1];
            off_d        = 1'b0;
            // A same-cycle ack retires the old request; otherwise its ack must be swallowed.
            pend_d       = pend_q && !ic_ack;
            drop_d       = pend_q && !ic_ack;
        end else begin
            if (issue) begin
                req_addr_d   = fetch_addr_q;
                fetch_addr_d = fetch_addr_q + ADDR_W'(4);
                pend_d       = 1'b1;
            end
            if (ack_live) begin
                pend_d = 1'b0;
                drop_d = 1'b0;
            end
            // The first word after a redirect always lands in an empty queue, so no consume overlaps it.
            if (push && poff_q) begin
                off_d  = 1'b1;
                poff_d = 1'b0;
            end else if (consume) begin
                off_d = !off_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_addr_q <= RESET_PC;
            req_addr_q   <= RESET_PC;
            pend_q       <= 1'b0;
            drop_q       <= 1'b0;
            off_q        <= 1'b0;
            poff_q       <= 1'b0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            req_addr_q   <= req_addr_d;
            pend_q       <= pend_d;
            drop_q       <= drop_d;
            off_q        <= off_d;
            poff_q       <= poff_d;
        end
    end

    assign ic_addr = fetch_addr_q;
    assign hw_data = hw_valid ? hw_select(head.data, off_q) : 16'h0000;
    assign hw_pc   = hw_valid ? (ADDR_W'(head.addr) + (off_q ? ADDR_W'(HW_BYTES) : ADDR_W'(0)))
                              : fetch_addr_q;
endmodule

// File: tb/tb_halfword_fetch_ctrl.sv
// Bench for halfword_fetch_ctrl: cache/consumer model plus a half-word scoreboard.
module tb_halfword_fetch_ctrl;
    localparam int          AW  = 32;
    localparam logic [31:0] RPC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_rdy;
    logic        ic_ack;
    logic [31:0] ic_rdata;
    logic        hw_valid;
    logic [15:0] hw_data;
    logic [31:0] hw_pc;
    logic        hw_ready;

    always #5 clk = ~clk;

    halfword_fetch_ctrl #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ic_req         (ic_req),
        .ic_addr        (ic_addr),
        .ic_rdy         (ic_rdy),
        .ic_ack         (ic_ack),
        .ic_rdata       (ic_rdata),
        .hw_valid       (hw_valid),
        .hw_data        (hw_data),
        .hw_pc          (hw_pc),
        .hw_ready       (hw_ready)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] data;
    } hw_t;

    // Expected half-word stream, oldest first.
    hw_t         expq[$];
    logic [31:0] m_fetch = RPC;
    logic [31:0] out_addr = 32'h0;
    bit          out_busy = 0, stale = 0, skip_hi = 0, rst_seen = 0;
    int          ack_wait = 0;
    int          fix_lat = 0;
    bit          fix_data_en = 0, force_ack = 0, seen40 = 0;
    logic [31:0] fix_data = 32'h0, last_ack_data = 32'h0;

    logic        obs_req, obs_valid;
    logic [31:0] obs_addr, obs_pc;
    logic [15:0] obs_data;

    int checks = 0, passes = 0, fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int words_held();
        int n = 0;
        for (int i = 0; i < expq.size(); i++)
            if (i == 0 || expq[i].pc[31:2] != expq[i-1].pc[31:2]) n++;
        return n;
    endfunction

    // One clock cycle: caller has set rst/redirect/ic_rdy/hw_ready; the cache model drives the ack.
    task automatic cycle();
        bit ack_now, exp_req;
        ack_now  = out_busy && (ack_wait == 0);
        ic_ack   = ack_now || force_ack;
        ic_rdata = fix_data_en ? fix_data : $urandom;
        @(negedge clk);
        obs_req   = ic_req;
        obs_addr  = ic_addr;
        obs_valid = hw_valid;
        obs_pc    = hw_pc;
        obs_data  = hw_data;
        exp_req   = 0;
        if (rst) begin
            check("req_in_reset", ic_req, 0);
            if (rst_seen) begin
                check("rst_hw_valid", hw_valid, 0);
                check("rst_hw_data", hw_data, 0);
                check("rst_hw_pc", hw_pc, RPC);
                check("rst_ic_addr", ic_addr, RPC);
            end
        end else begin
            exp_req = !redirect_valid && !out_busy && (words_held() < 2);
            check("ic_req", ic_req, exp_req);
            if (exp_req) check("ic_addr", ic_addr, m_fetch);
            check("hw_valid", hw_valid, expq.size() != 0);
            if (expq.size() != 0) begin
                check("hw_pc", hw_pc, expq[0].pc);
                check("hw_data", hw_data, expq[0].data);
            end
            if (hw_valid === 1'b1 && hw_pc[31:2] == 30'h10) seen40 = 1;
        end

        if (out_busy && !ack_now) ack_wait--;
        if (rst) begin
            expq.delete();
            m_fetch  = RPC;
            out_busy = 0;
            stale    = 0;
            skip_hi  = 0;
            rst_seen = 1;
        end else begin
            rst_seen = 0;
            if (redirect_valid) begin
                expq.delete();
                m_fetch = redirect_pc & ~32'h3;
                skip_hi = redirect_pc[1];
                if (ack_now) begin
                    out_busy = 0;
                    stale    = 0;
                end else if (out_busy) begin
                    stale = 1;
                end
            end else begin
                if (expq.size() != 0 && hw_ready) expq.delete(0);
                if (ack_now) begin
                    out_busy = 0;
                    if (stale) stale = 0;
                    else begin
                        last_ack_data = ic_rdata;
                        if (!skip_hi) expq.push_back(hw_t'{pc: out_addr, data: ic_rdata[31:16]});
                        expq.push_back(hw_t'{pc: out_addr + 32'd2, data: ic_rdata[15:0]});
                        skip_hi = 0;
                    end
                end
                if (exp_req && ic_rdy) begin
                    out_busy = 1;
                    out_addr = m_fetch;
                    m_fetch  = m_fetch + 32'd4;
                    ack_wait = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        ic_rdy   = 0;
        hw_ready = 1;
        for (int i = 0; i < 8 && out_busy; i++) cycle();
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        redirect_valid = 1;
        redirect_pc    = tgt;
        ic_rdy         = 1;
        cycle();
        redirect_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        bit          found, stall_ok, saw_fe, wrapped;
        int          nvalid;
        logic [31:0] prev_pc;
        logic [15:0] hold_data;

        rst = 1; redirect_valid = 0; redirect_pc = 0;
        ic_rdy = 1; hw_ready = 1; ic_ack = 0; ic_rdata = 0;

        // Reset release, first word 0xAAAA_BBBB one cycle after the request
        repeat (3) cycle();
        rst = 0; fix_lat = 0; fix_data_en = 1; fix_data = 32'hAAAA_BBBB;
        cycle();
        check("t1_first_req", obs_req, 1);
        check("t1_first_addr", obs_addr, RPC);
        cycle();
        cycle();
        check("t1_valid", obs_valid, 1);
        check("t1_data_hi", obs_data, 16'hAAAA);
        check("t1_pc_hi", obs_pc, 32'h0);
        cycle();
        check("t1_data_lo", obs_data, 16'hBBBB);
        check("t1_pc_lo", obs_pc, 32'h2);
        fix_data_en = 0;

        // Back-to-back streaming
        nvalid = 0; prev_pc = obs_pc; found = 1;
        repeat (16) begin
            cycle();
            if (obs_valid === 1'b1) nvalid++;
            if (obs_pc !== prev_pc + 32'd2) found = 0;
            prev_pc = obs_pc;
        end
        check("t2_valid_cycles", nvalid, 16);
        check("t2_pc_step", found, 1);

        // Stall at hw_pc 0x6 for 5 cycles
        do_redirect(32'h0);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            hw_ready = !(expq.size() != 0 && expq[0].pc == 32'h6);
            cycle();
            if (!hw_ready) found = 1;
        end
        check("t3_reach_pc6", found, 1);
        hold_data = obs_data; stall_ok = (obs_pc === 32'h6);
        repeat (4) begin
            cycle();
            if (obs_pc !== 32'h6 || obs_data !== hold_data) stall_ok = 0;
        end
        check("t3_held", stall_ok, 1);
        check("t3_req_full", obs_req, 0);
        hw_ready = 1;
        cycle();
        cycle();
        check("t3_resume_pc", obs_pc, 32'h8);

        // Redirect to a half-word offset target
        drain();
        do_redirect(32'h102);
        cycle();
        check("t4_req", obs_req, 1);
        check("t4_addr", obs_addr, 32'h100);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            if (obs_valid === 1'b1) found = 1;
        end
        check("t4_valid_seen", found, 1);
        check("t4_pc", obs_pc, 32'h102);
        check("t4_data", obs_data, last_ack_data[15:0]);

        // Redirect with a request in flight
        drain();
        seen40 = 0;
        do_redirect(32'h40);
        fix_lat = 3;
        cycle();
        check("t5_req40", obs_addr, 32'h40);
        do_redirect(32'h80);
        fix_lat = 0;
        for (int i = 0; i < 8 && out_busy; i++) cycle();
        cycle();
        check("t5_req80", obs_req, 1);
        check("t5_addr80", obs_addr, 32'h80);
        repeat (6) cycle();
        check("t5_no_stale", seen40, 0);

        // Redirect and ack in the same cycle
        drain();
        do_redirect(32'h200);
        fix_lat = 1;
        cycle();
        for (int i = 0; i < 8 && !(out_busy && ack_wait == 0); i++) cycle();
        redirect_valid = 1; redirect_pc = 32'h300;
        cycle();
        redirect_valid = 0; fix_lat = 0;
        cycle();
        check("t6_req", obs_req, 1);
        check("t6_addr", obs_addr, 32'h300);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            if (obs_valid === 1'b1) found = 1;
        end
        check("t6_valid_seen", found, 1);
        check("t6_pc", obs_pc, 32'h300);

        // Reset mid-operation with a bogus ack right after
        do_redirect(32'h500);
        fix_lat = 2;
        cycle();
        rst = 1;
        cycle();
        rst = 0; force_ack = 1; fix_lat = 0;
        cycle();
        force_ack = 0;
        check("t7_req", obs_req, 1);
        check("t7_addr", obs_addr, RPC);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            if (obs_valid === 1'b1) found = 1;
        end
        check("t7_valid_seen", found, 1);
        check("t7_pc", obs_pc, RPC);

        // Address wrap past the top of memory
        do_redirect(32'hFFFF_FFFA);
        saw_fe = 0; wrapped = 0;
        repeat (14) begin
            cycle();
            if (obs_valid === 1'b1 && obs_pc == 32'hFFFF_FFFE) saw_fe = 1;
            if (obs_valid === 1'b1 && obs_pc == 32'h0 && saw_fe) wrapped = 1;
        end
        check("t8_wrap", wrapped, 1);

        // Randomized traffic against the scoreboard
        fix_lat = -1;
        repeat (400) begin
            hw_ready       = ($urandom_range(0, 3) != 0);
            ic_rdy         = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom & 32'h0001_FFFF;
            cycle();
        end
        redirect_valid = 0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
